// File: rtl/matmul_tile_sequencer.sv
// Control FSM for one matrix-multiply job: walks C[i][j] over K in half-row chunks,
// issuing operand reads, PE strobes aligned to RAM data, and packed result writes.
module matmul_tile_sequencer #(
  parameter int M      = 8,
  parameter int N      = 8,
  parameter int HALVES = 2,
  parameter int LANES  = 4,
  parameter int PE_LAT = 2,
  parameter int AW     = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       valid,
  input  logic                                       hold,
  output logic                                       rd_en,
  output logic [AW-1:0]                              rd_addr_a,
  output logic [AW-1:0]                              rd_addr_b,
  output logic                                       pe_clr,
  output logic                                       pe_en,
  output logic                                       wr_en,
  output logic [AW-1:0]                              wr_addr,
  output logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] wr_lane,
  output logic                                       busy,
  output logic                                       stop
);

  localparam int IW    = (M > 1) ? $clog2(M) : 1;
  localparam int JW    = (N > 1) ? $clog2(N) : 1;
  localparam int HW    = (HALVES > 1) ? $clog2(HALVES) : 1;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int DEPTH = 1 + PE_LAT;
  localparam int LPR   = N / LANES;

  if (M * HALVES > 2 ** AW || N * HALVES > 2 ** AW || (M * N) / LANES > 2 ** AW) begin : g_aw_too_small
    $error("matmul_tile_sequencer: AW too small for M/N/HALVES/LANES");
  end
  if (N % LANES != 0 || PE_LAT < 1) begin : g_bad_shape
    $error("matmul_tile_sequencer: N must be a multiple of LANES and PE_LAT >= 1");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   i_reg, i_next;
  logic [JW-1:0]   j_reg, j_next;
  logic [HW-1:0]   h_reg, h_next;
  logic            issue;
  logic            drain_empty;

  logic            pipe_v_reg    [DEPTH];
  logic            pipe_clr_reg  [DEPTH];
  logic            pipe_last_reg [DEPTH];
  logic [IW-1:0]   pipe_i_reg    [DEPTH];
  logic [JW-1:0]   pipe_j_reg    [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      i_reg     <= '0;
      j_reg     <= '0;
      h_reg     <= '0;
    end else begin
      state_reg <= state_next;
      i_reg     <= i_next;
      j_reg     <= j_next;
      h_reg     <= h_next;
    end
  end

  // Drain completes once the entry now in the last stage is the only one left.
  always_comb begin
    drain_empty = 1'b1;
    for (int s = 0; s < DEPTH - 1; s++) begin
      if (pipe_v_reg[s]) drain_empty = 1'b0;
    end
  end

  always_comb begin
    state_next = state_reg;
    i_next     = i_reg;
    j_next     = j_reg;
    h_next     = h_reg;
    issue      = 1'b0;
    if (!hold) begin
      case (state_reg)
        IDLE: begin
          if (valid) begin
            state_next = RUN;
            i_next     = '0;
            j_next     = '0;
            h_next     = '0;
          end
        end
        RUN: begin
          issue = 1'b1;
          if (h_reg == HW'(HALVES - 1)) begin
            h_next = '0;
            if (j_reg == JW'(N - 1)) begin
              j_next = '0;
              if (i_reg == IW'(M - 1)) begin
                i_next     = '0;
                state_next = DRAIN;
              end else begin
                i_next = i_reg + 1'b1;
              end
            end else begin
              j_next = j_reg + 1'b1;
            end
          end else begin
            h_next = h_reg + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_empty) state_next = DONE;
        end
        DONE: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pipe_v_reg[gi]    <= 1'b0;
          pipe_clr_reg[gi]  <= 1'b0;
          pipe_last_reg[gi] <= 1'b0;
          pipe_i_reg[gi]    <= '0;
          pipe_j_reg[gi]    <= '0;
        end else if (!hold) begin
          pipe_v_reg[gi]    <= issue;
          pipe_clr_reg[gi]  <= (h_reg == '0);
          pipe_last_reg[gi] <= (h_reg == HW'(HALVES - 1));
          pipe_i_reg[gi]    <= i_reg;
          pipe_j_reg[gi]    <= j_reg;
        end
      end
    end else begin : g_tail
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pipe_v_reg[gi]    <= 1'b0;
          pipe_clr_reg[gi]  <= 1'b0;
          pipe_last_reg[gi] <= 1'b0;
          pipe_i_reg[gi]    <= '0;
          pipe_j_reg[gi]    <= '0;
        end else if (!hold) begin
          pipe_v_reg[gi]    <= pipe_v_reg[gi-1];
          pipe_clr_reg[gi]  <= pipe_clr_reg[gi-1];
          pipe_last_reg[gi] <= pipe_last_reg[gi-1];
          pipe_i_reg[gi]    <= pipe_i_reg[gi-1];
          pipe_j_reg[gi]    <= pipe_j_reg[gi-1];
        end
      end
    end
  end

  assign rd_en     = issue;
  assign rd_addr_a = AW'(i_reg) * AW'(HALVES) + AW'(h_reg);
  assign rd_addr_b = AW'(j_reg) * AW'(HALVES) + AW'(h_reg);
  assign pe_en     = pipe_v_reg[0] && !hold;
  assign pe_clr    = pipe_v_reg[0] && pipe_clr_reg[0] && !hold;
  assign wr_en     = pipe_v_reg[DEPTH-1] && pipe_last_reg[DEPTH-1] && !hold;
  assign busy      = (state_reg == RUN) || (state_reg == DRAIN);
  assign stop      = (state_reg == DONE) && !hold;

  always_comb begin
    int jl;
    jl      = int'(pipe_j_reg[DEPTH-1]);
    wr_addr = AW'(pipe_i_reg[DEPTH-1]) * AW'(LPR) + AW'(jl / LANES);
    wr_lane = LW'(jl % LANES);
  end

endmodule
